// File: rtl/lfsr_noise_sampler.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_noise_sampler
// Purpose  : Packs LFSR bytes into 16-bit signed uniform or triangular noise
//            samples, applies an attenuation shift, and queues them in a FWFT FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_noise_sampler #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [7:0]                    lfsr_in,
  input  logic                          mode,
  input  logic [3:0]                    atten,
  output logic [15:0]                   out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fill
);

  localparam int                   c_PTR_W  = $clog2(FIFO_DEPTH);
  localparam int                   c_FILL_W = c_PTR_W + 1;
  localparam logic [c_FILL_W-1:0]  c_FULL   = c_FILL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_COMPUTE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  mode_q, mode_d;
  logic [3:0]            atten_q, atten_d;
  logic [7:0]            byte_q [4];
  logic                  w_capture;
  logic                  w_push;
  logic                  w_pop;
  logic [1:0]            w_last;

  logic [15:0]           mem_q [FIFO_DEPTH];
  logic [c_PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [c_FILL_W-1:0]   fill_q, fill_d;

  logic signed [15:0]    w_u0, w_u1, w_tri, w_sel, w_sample;

  // Triangular needs two 16-bit words, uniform only one.
  assign w_last = mode_q ? 2'd3 : 2'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    atten_d   = atten_q;
    w_capture = 1'b0;
    w_push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en && (fill_q < c_FULL)) begin
          state_d = S_COLLECT;
          cnt_d   = 2'd0;
          mode_d  = mode;
          atten_d = atten;
        end
      end
      S_COLLECT: begin
        w_capture = 1'b1;
        if (cnt_q == w_last) begin
          state_d = S_COMPUTE;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_COMPUTE: begin
        w_push  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      mode_q  <= 1'b0;
      atten_q <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      atten_q <= atten_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        byte_q[i] <= 8'h00;
      end
    end else if (w_capture) begin
      byte_q[cnt_q] <= lfsr_in;
    end
  end

  // Halving each word before the add keeps the triangular sum inside 16 bits.
  assign w_u0     = $signed({byte_q[0], byte_q[1]});
  assign w_u1     = $signed({byte_q[2], byte_q[3]});
  assign w_tri    = (w_u0 >>> 1) + (w_u1 >>> 1);
  assign w_sel    = mode_q ? w_tri : w_u0;
  assign w_sample = w_sel >>> atten_q;

  // A collection only starts with room available, so a push never sees a full FIFO.
  assign w_pop     = out_valid && out_ready;
  assign out_valid = (fill_q != '0);
  assign out_data  = mem_q[rd_ptr_q];
  assign fill      = fill_q;
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    fill_d = fill_q;
    case ({w_push, w_pop})
      2'b10:   fill_d = fill_q + c_FILL_W'(1);
      2'b01:   fill_d = fill_q - c_FILL_W'(1);
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 16'h0000;
      end
    end else begin
      fill_q <= fill_d;
      if (w_push) begin
        mem_q[wr_ptr_q] <= w_sample;
        wr_ptr_q        <= wr_ptr_q + c_PTR_W'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lfsr_noise_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_noise_sampler
// Purpose  : Self-checking bench for lfsr_noise_sampler with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_noise_sampler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [7:0]  lfsr_in = 8'h00;
  logic        mode = 1'b0;
  logic [3:0]  atten = 4'd0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic [2:0]  fill;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lfsr_noise_sampler #(.FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .lfsr_in   (lfsr_in),
    .mode      (mode),
    .atten     (atten),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .fill      (fill)
  );

  // Reference model: integer arithmetic with floor division for arithmetic shifts.
  logic [15:0] exp_q[$];
  logic [7:0]  m_bytes[$];
  int          m_phase = 0;
  bit          m_mode = 1'b0;
  int          m_atten = 0;

  function automatic int fdiv(input int x, input int d);
    if (x >= 0) return x / d;
    return -((-x + d - 1) / d);
  endfunction

  function automatic int to_s16(input logic [7:0] hi, input logic [7:0] lo);
    int v;
    v = int'(hi) * 256 + int'(lo);
    if (v >= 32768) v = v - 65536;
    return v;
  endfunction

  function automatic logic [15:0] ref_sample(input bit m, input int a, input logic [7:0] b0,
                                             input logic [7:0] b1, input logic [7:0] b2,
                                             input logic [7:0] b3);
    int s;
    if (!m) s = to_s16(b0, b1);
    else    s = fdiv(to_s16(b0, b1), 2) + fdiv(to_s16(b2, b3), 2);
    return 16'(fdiv(s, 1 << a));
  endfunction

  always @(posedge clk) begin
    int          old_size;
    bit          do_push;
    logic [15:0] val;
    do_push = 1'b0;
    val     = 16'h0;
    if (rst) begin
      exp_q.delete();
      m_bytes.delete();
      m_phase = 0;
    end else begin
      old_size = exp_q.size();
      case (m_phase)
        0: if (en && old_size < 4) begin
             m_phase = 1;
             m_mode  = mode;
             m_atten = int'(atten);
             m_bytes.delete();
           end
        1: begin
             m_bytes.push_back(lfsr_in);
             if (m_bytes.size() == (m_mode ? 4 : 2)) m_phase = 2;
           end
        default: begin
             do_push = 1'b1;
             val = ref_sample(m_mode, m_atten, m_bytes[0], m_bytes[1],
                              m_mode ? m_bytes[2] : 8'h00, m_mode ? m_bytes[3] : 8'h00);
             m_phase = 0;
           end
      endcase
      if (old_size > 0 && out_ready) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(val);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; out_ready = 1'b0; lfsr_in = 8'($urandom);
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic collect(input bit m, input logic [3:0] a, input logic [7:0] b0,
                         input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    en = 1'b1; mode = m; atten = a; lfsr_in = 8'($urandom);
    tick();
    en = 1'b0; mode = 1'($urandom); atten = 4'($urandom);
    lfsr_in = b0; tick();
    lfsr_in = b1; tick();
    if (m) begin
      lfsr_in = b2; tick();
      lfsr_in = b3; tick();
    end
    lfsr_in = 8'($urandom);
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      lfsr_in = 8'($urandom);
      tick();
    end
    checks++; if (fill !== 3'd0) begin errors++; $display("FAIL reset_fill: got %0d expected 0", fill); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected 0000", out_data); end
    rst = 1'b0; en = 1'b0;
    tick();
  endtask

  task automatic test_uniform();
    do_reset();
    en = 1'b1; mode = 1'b0; atten = 4'd0; lfsr_in = 8'($urandom);
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL uni_busy_start: got %b expected 1", busy); end
    en = 1'b0; lfsr_in = 8'h12;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL uni_valid_early1: got %b expected 0", out_valid); end
    lfsr_in = 8'h34;
    tick();
    lfsr_in = 8'($urandom);
    checks++; if (busy !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL uni_compute: got busy=%b valid=%b expected busy=1 valid=0", busy, out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL uni_valid: got %b expected 1", out_valid); end
    checks++; if (out_data !== 16'h1234) begin errors++; $display("FAIL uni_data: got %h expected 1234", out_data); end
    checks++; if (busy !== 1'b0 || fill !== 3'd1) begin errors++; $display("FAIL uni_done: got busy=%b fill=%0d expected busy=0 fill=1", busy, fill); end
  endtask

  task automatic test_triangular();
    do_reset();
    collect(1'b1, 4'd0, 8'h40, 8'h00, 8'hC0, 8'h00);
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h0000) begin errors++; $display("FAIL tri_zero: got valid=%b data=%h expected valid=1 data=0000", out_valid, out_data); end
    do_reset();
    collect(1'b1, 4'd0, 8'h40, 8'h00, 8'h40, 8'h00);
    checks++; if (out_data !== 16'h4000) begin errors++; $display("FAIL tri_pos: got %h expected 4000", out_data); end
    do_reset();
    collect(1'b1, 4'd0, 8'h80, 8'h00, 8'h80, 8'h01);
    checks++; if (out_data !== 16'h8000) begin errors++; $display("FAIL tri_neg: got %h expected 8000", out_data); end
  endtask

  task automatic test_atten();
    do_reset();
    collect(1'b0, 4'd4, 8'h12, 8'h34, 8'h00, 8'h00);
    checks++; if (out_data !== 16'h0123) begin errors++; $display("FAIL att_4: got %h expected 0123", out_data); end
    do_reset();
    collect(1'b0, 4'd15, 8'h80, 8'h00, 8'h00, 8'h00);
    checks++; if (out_data !== 16'hFFFF) begin errors++; $display("FAIL att_15_neg: got %h expected ffff", out_data); end
    do_reset();
    collect(1'b0, 4'd15, 8'h7F, 8'hFF, 8'h00, 8'h00);
    checks++; if (out_data !== 16'h0000 || out_valid !== 1'b1) begin errors++; $display("FAIL att_15_pos: got valid=%b data=%h expected valid=1 data=0000", out_valid, out_data); end
  endtask

  task automatic test_backpressure();
    logic [15:0] snap[$];
    do_reset();
    en = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      mode = 1'($urandom); atten = 4'($urandom); lfsr_in = 8'($urandom);
      tick();
    end
    checks++; if (fill !== 3'd4) begin errors++; $display("FAIL bp_fill: got %0d expected 4", fill); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_busy: got %b expected 0", busy); end
    snap = exp_q;
    checks++; if (snap.size() != 4 || out_data !== snap[0]) begin errors++; $display("FAIL bp_head: got %h expected %h", out_data, (snap.size() > 0) ? snap[0] : 16'h0); end
    en = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (fill !== 3'(4 - i) || out_data !== snap[i]) begin
        errors++; $display("FAIL bp_drain%0d: got fill=%0d data=%h expected fill=%0d data=%h", i, fill, out_data, 4 - i, snap[i]);
      end
      tick();
    end
    checks++; if (fill !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got fill=%0d valid=%b expected 0 0", fill, out_valid); end
    en = 1'b1;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bp_resume: got busy=%b expected 1", busy); end
    en = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic test_reset_mid();
    bit reached;
    do_reset();
    reached = 1'b0;
    en = 1'b1; out_ready = 1'b0; mode = 1'b0; atten = 4'd0;
    for (int i = 0; i < 60 && !reached; i++) begin
      lfsr_in = 8'($urandom);
      tick();
      if (exp_q.size() == 2 && m_phase == 1) reached = 1'b1;
    end
    checks++; if (!reached) begin errors++; $display("FAIL rstmid_setup: got no 2-queued COLLECT cycle expected one within 60 cycles"); end
    rst = 1'b1; en = 1'b0;
    tick();
    checks++; if (fill !== 3'd0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_clear: got fill=%0d valid=%b busy=%b expected 0 0 0", fill, out_valid, busy);
    end
    rst = 1'b0;
    collect(1'b0, 4'd0, 8'hAB, 8'hCD, 8'h00, 8'h00);
    checks++; if (out_data !== 16'hABCD || fill !== 3'd1) begin errors++; $display("FAIL rstmid_next: got data=%h fill=%0d expected abcd 1", out_data, fill); end
  endtask

  task automatic test_mode_change();
    do_reset();
    en = 1'b1; mode = 1'b0; atten = 4'd0; lfsr_in = 8'($urandom);
    tick();
    en = 1'b0; mode = 1'b1; atten = 4'd7; lfsr_in = 8'h5A;
    tick();
    lfsr_in = 8'hA5;
    tick();
    lfsr_in = 8'($urandom);
    tick();
    checks++; if (busy !== 1'b0 || fill !== 3'd1 || out_data !== 16'h5AA5) begin
      errors++; $display("FAIL mode_cur: got busy=%b fill=%0d data=%h expected 0 1 5aa5", busy, fill, out_data);
    end
    collect(1'b1, 4'd0, 8'h20, 8'h00, 8'h10, 8'h00);
    checks++; if (fill !== 3'd2 || out_data !== 16'h5AA5) begin errors++; $display("FAIL mode_hold: got fill=%0d data=%h expected 2 5aa5", fill, out_data); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++; if (fill !== 3'd1 || out_data !== 16'h1800) begin errors++; $display("FAIL mode_next: got fill=%0d data=%h expected 1 1800", fill, out_data); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      rst       = ($urandom_range(199, 0) == 0);
      en        = ($urandom_range(3, 0) != 0);
      out_ready = 1'($urandom);
      mode      = 1'($urandom);
      atten     = 4'($urandom);
      lfsr_in   = 8'($urandom);
      tick();
      checks++;
      if (fill !== 3'(exp_q.size()) || out_valid !== (exp_q.size() > 0) || busy !== (m_phase != 0)) begin
        errors++; $display("FAIL rnd_status@%0d: got fill=%0d valid=%b busy=%b expected fill=%0d busy=%0d", i, fill, out_valid, busy, exp_q.size(), m_phase != 0);
      end
      if (exp_q.size() > 0) begin
        checks++;
        if (out_data !== exp_q[0]) begin errors++; $display("FAIL rnd_data@%0d: got %h expected %h", i, out_data, exp_q[0]); end
      end
    end
    rst = 1'b0; en = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick();
    test_reset();
    test_uniform();
    test_triangular();
    test_atten();
    test_backpressure();
    test_reset_mid();
    test_mode_change();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lfsr_noise_sampler.md
# lfsr_noise_sampler

Consumes the free-running 8-bit Galois LFSR byte stream and turns it into 16-bit signed noise samples for the DSP testbench's stimulus path. It supports uniform or triangular amplitude distribution and a programmable attenuation. Finished samples are delivered through a 4-entry first-word-fall-through FIFO with a valid/ready handshake. The block sits directly downstream of the LFSR, whose output advances every clock, and upstream of any sample consumer (adders, filters, DAC models).

## Interface
- FIFO_DEPTH, 4: output FIFO entries; must be a power of two, at least 2.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  permits starting a new sample collection.
- lfsr_in  in  8  LFSR state; a new value arrives every cycle.
- mode  in  1  0 = uniform, 1 = triangular.
- atten  in  4  arithmetic right-shift amount applied to the sample, 0..15.
- out_data  out  16  signed sample at the FIFO head.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data this cycle.
- busy  out  1  FSM is not in IDLE.
- fill  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- FSM states:
  - IDLE: goes to COLLECT when en=1 and fill<FIFO_DEPTH.
  - COLLECT: captures lfsr_in into byte slot cnt each cycle, with cnt running from 0 to N-1. Goes to COMPUTE after capturing byte N-1.
  - COMPUTE: forms the sample, pushes it into the FIFO, and returns to IDLE unconditionally.
- mode and atten are latched on the IDLE→COLLECT transition. Changes during COLLECT or COMPUTE affect the next sample only.
- N is 2 for uniform and 4 for triangular. Byte b0 is the first byte captured.
- Uniform sample: s = {b0,b1}, interpreted as two's complement.
- Triangular sample:
  - u0 = {b0,b1}, u1 = {b2,b3}, both signed.
  - s = (u0>>>1) + (u1>>>1), computed in 16 bits; the sum cannot overflow.
- Output: out = s >>> atten_latched. This is an arithmetic shift, so the sign is preserved. Example: 0x8000 with atten=15 gives 0xFFFF.
- Deasserting en mid-collection does not abort; the current sample completes and is pushed.
- FIFO behaviour:
  - First-word fall-through: out_data always shows the head entry.
  - A pop occurs when out_valid && out_ready.
  - A push occurs only in COMPUTE. A collection starts only when fill<FIFO_DEPTH and only one sample is in flight, so a push never meets a full FIFO and no overflow path exists.
  - Push and pop in the same cycle leave fill unchanged, and the data order is preserved.
  - Pointers wrap modulo FIFO_DEPTH.
- Popping an empty FIFO (out_ready=1, out_valid=0) has no effect.
- out_data is don't-care while out_valid=0, but must be stable (not X) after reset.

## Timing
- Reset values: FSM=IDLE, cnt=0, fill=0, out_valid=0, busy=0, out_data=0x0000, FIFO pointers=0.
- rst asserted at any point, including mid-COLLECT, discards the partial sample and all FIFO contents on the next edge.
- Start condition: en=1 and room in the FIFO sampled at edge T. The COLLECT cycles are T+1 through T+N, and lfsr_in is captured on each of those edges.
- COMPUTE occupies cycle T+N+1. The entry is written at the end of that cycle, and out_valid rises in cycle T+N+2 if the FIFO was empty.
- Latency from start to out_valid: N+2 cycles. Uniform takes 4 cycles, triangular 6.
- Sustained throughput (en held, consumer always ready): one sample every N+2 cycles.
- busy is high from cycle T+1 through T+N+1 inclusive.
- out_data/out_valid change only on clock edges. They must stay stable while out_valid=1 and out_ready=0.
- fill updates on the same edge as the push or pop.

## Test plan
- Uniform:
  - Stimulus: mode=0, atten=0; lfsr_in=0x12 then 0x34 on the two COLLECT cycles.
  - Required: out_data=0x1234, with out_valid rising 4 cycles after the start edge.
- Triangular:
  - Stimulus: mode=1, atten=0; bytes 0x40,0x00,0xC0,0x00.
  - Required: out_data=0x0000. Bytes 0x40,0x00,0x40,0x00 give 0x4000.
- Attenuation:
  - Stimulus: mode=0, bytes 0x12,0x34, atten=4.
  - Required: out_data=0x0123. Bytes 0x80,0x00 with atten=15 give 0xFFFF.
- Backpressure:
  - Stimulus: en=1, out_ready=0.
  - Required: fill reaches 4 and busy stays 0 afterwards. out_data holds the first sample.
  - Then out_ready=1: samples drain in generation order, fill steps 4→0, and collection resumes.
- Reset mid-operation:
  - Stimulus: assert rst during COLLECT with 2 samples queued.
  - Required: next cycle fill=0, out_valid=0, busy=0. The next sample uses only bytes captured after reset.
- Mode change mid-collection:
  - Stimulus: toggle mode during COLLECT.
  - Required: the current sample uses the latched mode and byte count, and the next sample uses the new mode.
